bram_tdp_be_pipe: RTL and testbench
===================================

// Module: bram_tdp_be_pipe
// PURPOSE
//  Single-clock true dual-port block RAM with per-byte write enables, selectable
//  read-during-write mode, optional output pipeline register, read-valid strobes
//  and cross-port collision detection. Feature buffer for systolic array, shared
//  by AXI DMA write side (port A) and PE-array read/writeback side (port B).
//  Infers one or more BRAM36 tiles on Pynq-Z1.
// PARAMETERS
//  DWIDTH    32    data width per port, multiple of 8
//  DEPTH     2048  number of words
//  ADDR_BIT  11    address width, >= clog2(DEPTH)
//  RD_MODE   0     same-port read-during-write: 0 read-first, 1 write-first, 2 no-change
//  OUT_REG   1     1 adds output pipeline register (read latency 2), 0 gives latency 1
//  NB        DWIDTH/8  byte lanes (derived, not overridden)
// PORTS
//  clk        in   1         single clock, rising edge
//  rst        in   1         async active-high reset
//  en_a       in   1         port A access enable
//  we_a       in   NB        port A byte write enables, bit i covers d_in_a[8i+7:8i]
//  addr_a     in   ADDR_BIT  port A word address
//  d_in_a     in   DWIDTH    port A write data
//  d_out_a    out  DWIDTH    port A read data
//  valid_a    out  1         d_out_a holds data for an access issued LAT cycles earlier
//  en_b/we_b/addr_b/d_in_b/d_out_b/valid_b  as port A, for port B
//  collision  out  1         registered flag: same-cycle A/B conflict occurred
// BEHAVIOUR
//  - Reset: rst is asynchronous and active-high. d_out_a/b, valid_a/b, collision and all
//    pipeline regs are 0 while rst=1. Memory array is NOT reset. rst asserted mid-burst
//    drops in-flight reads (no valid). Access on the first edge after release is honoured.
//  - LAT = 1 + OUT_REG. Access with en_x=1 at edge N gives d_out_x/valid_x=1 at edge N+LAT.
//    valid_x is a delayed copy of en_x. The enable bubble propagates as valid_x=0.
//  - en_x=0: no read or write. The stage-1 data reg holds its value. valid stays 0.
//  - Write: each lane i with we_x[i]=1 updates mem[addr_x] byte i. Other lanes are unchanged.
//  - Read on the same port as a write (en_x=1, we_x!=0):
//    - RD_MODE=0: returns the old word.
//    - RD_MODE=1: returns the new word, with unwritten lanes showing old bytes.
//    - RD_MODE=2: stage-1 reg holds its previous value. valid_x still pulses.
//  - Out-of-range address (addr_x >= DEPTH): the write is dropped and the read returns 0.
//    valid_x still pulses. No wrap-around.
//  - Cross-port, same cycle, addr_a==addr_b, both in range, both enabled:
//    - A reads, B writes (or the reverse): the reader gets the old word, in any RD_MODE.
//    - Both write: for lanes enabled on both ports, port A data is stored. Lanes enabled
//      on one port take that port's data.
//    - Both read only: no conflict, no flag.
//  - collision: 1 for exactly one cycle, on the edge after any conflicting access above
//    (at least one port writing). Otherwise 0.
//  - Both ports always accept; there is no back-pressure.
//  - OUT_REG=1: stage-2 reg loads stage-1 every cycle.
// TESTING
//  1 rst=1 mid-traffic -> all outputs 0 at once (async). After release, mem contents from
//    before reset read back unchanged.
//  2 A writes 0xDEADBEEF @5 we=4'hF, then A writes 0x11223344 @5 we=4'b0101
//    -> B read @5 gives 0xDE22BE44, valid_b exactly LAT cycles after en_b (LAT=1 and LAT=2).
//  3 Mem[7]=0xAAAA0000. A writes 0x5555FFFF @7 we=4'hF while A reads
//    -> RD_MODE0: 0xAAAA0000; RD_MODE1: 0x5555FFFF; RD_MODE2: previous d_out_a held.
//    valid_a=1 in all modes.
//  4 Same cycle: A writes 0x01010101 @9 we=4'b0011, B writes 0x02020202 @9 we=4'b0110
//    -> mem[9] = 0x??020101 with byte3 unchanged. collision=1 for one cycle.
//  5 Same cycle: A reads @3 (mem=0x0), B writes 0x12345678 @3 -> d_out_a=0x0, collision=1.
//    Next A read @3 gives 0x12345678.
//  6 DEPTH=2000, ADDR_BIT=11: write @2047 -> dropped. Read @2047 -> 0 with valid.
//    mem[0] and mem[1999] are unchanged.

Source files
------------

// File: rtl/bram_tdp_be_pipe.sv
// bram_tdp_be_pipe: true dual-port byte-enable RAM with read-mode select, optional output register and collision flag
module bram_tdp_be_pipe #(
  parameter int DWIDTH   = 32,
  parameter int DEPTH    = 2048,
  parameter int ADDR_BIT = 11,
  parameter int RD_MODE  = 0,
  parameter int OUT_REG  = 1,
  localparam int NB      = DWIDTH / 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en_a,
  input  logic [NB-1:0]       we_a,
  input  logic [ADDR_BIT-1:0] addr_a,
  input  logic [DWIDTH-1:0]   d_in_a,
  output logic [DWIDTH-1:0]   d_out_a,
  output logic                valid_a,
  input  logic                en_b,
  input  logic [NB-1:0]       we_b,
  input  logic [ADDR_BIT-1:0] addr_b,
  input  logic [DWIDTH-1:0]   d_in_b,
  output logic [DWIDTH-1:0]   d_out_b,
  output logic                valid_b,
  output logic                collision
);
  localparam logic [ADDR_BIT:0] LIM = (ADDR_BIT + 1)'(DEPTH);
  logic [DWIDTH-1:0] mem [DEPTH];
  logic              in_a, in_b, wr_a, wr_b, col;
  logic [DWIDTH-1:0] old_a, old_b, mrg_a, mrg_b, nxt_a, nxt_b, s1_a, s1_b;
  logic              v1_a, v1_b;
  assign in_a  = {1'b0, addr_a} < LIM;
  assign in_b  = {1'b0, addr_b} < LIM;
  assign wr_a  = |we_a;
  assign wr_b  = |we_b;
  assign old_a = in_a ? mem[addr_a] : '0;
  assign old_b = in_b ? mem[addr_b] : '0;
  assign col   = en_a && en_b && in_a && in_b && addr_a == addr_b && (wr_a || wr_b);
  for (genvar i = 0; i < NB; i++) begin : g_lane
    assign mrg_a[8*i+:8] = we_a[i] ? d_in_a[8*i+:8] : old_a[8*i+:8];
    assign mrg_b[8*i+:8] = we_b[i] ? d_in_b[8*i+:8] : old_b[8*i+:8];
  end
  // stage-1 read value per port: out-of-range reads 0, otherwise chosen by read-during-write mode
  always_comb begin
    nxt_a = !in_a ? '0 : (!wr_a || RD_MODE == 0) ? old_a : (RD_MODE == 1) ? mrg_a : s1_a;
    nxt_b = !in_b ? '0 : (!wr_b || RD_MODE == 0) ? old_b : (RD_MODE == 1) ? mrg_b : s1_b;
  end
  // byte-lane writes; port A is applied last so it wins lanes both ports write
  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (en_b && in_b && we_b[i]) mem[addr_b][8*i+:8] <= d_in_b[8*i+:8];
      if (en_a && in_a && we_a[i]) mem[addr_a][8*i+:8] <= d_in_a[8*i+:8];
    end
  end
  // stage-1 data holds when the port is idle; valid and collision are plain registered copies
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_a      <= '0;
      s1_b      <= '0;
      v1_a      <= 1'b0;
      v1_b      <= 1'b0;
      collision <= 1'b0;
    end else begin
      if (en_a) s1_a <= nxt_a;
      if (en_b) s1_b <= nxt_b;
      v1_a      <= en_a;
      v1_b      <= en_b;
      collision <= col;
    end
  end
  if (OUT_REG != 0) begin : g_oreg
    logic [DWIDTH-1:0] s2_a, s2_b;
    logic              v2_a, v2_b;
    // output pipeline stage loads stage 1 every cycle
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s2_a <= '0;
        s2_b <= '0;
        v2_a <= 1'b0;
        v2_b <= 1'b0;
      end else begin
        s2_a <= s1_a;
        s2_b <= s1_b;
        v2_a <= v1_a;
        v2_b <= v1_b;
      end
    end
    assign d_out_a = s2_a;
    assign d_out_b = s2_b;
    assign valid_a = v2_a;
    assign valid_b = v2_b;
  end else begin : g_noreg
    assign d_out_a = s1_a;
    assign d_out_b = s1_b;
    assign valid_a = v1_a;
    assign valid_b = v1_b;
  end
endmodule

// File: tb/tb_bram_tdp_be_pipe.sv
// tb_bram_tdp_be_pipe: three RAM configurations on shared stimulus against a word-level reference model
module tb_bram_tdp_be_pipe;
  logic        clk = 1'b0;
  logic        rst;
  logic        en_a, en_b;
  logic [3:0]  we_a, we_b;
  logic [10:0] addr_a, addr_b;
  logic [31:0] d_in_a, d_in_b;
  logic [31:0] qa [3];
  logic [31:0] qb [3];
  logic        va [3];
  logic        vb [3];
  logic        co [3];
  int          dep  [3] = '{2048, 2000, 2048};
  int          mode [3] = '{0, 1, 2};
  int          lat  [3] = '{2, 1, 1};
  logic [31:0] mm [3][2048];
  logic [31:0] s1 [3][2];
  logic [31:0] s2 [3][2];
  logic        v1 [3][2];
  logic        v2 [3][2];
  logic        ce [3];
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  bram_tdp_be_pipe #(.DEPTH(2048), .RD_MODE(0), .OUT_REG(1)) d0 (
    .clk(clk), .rst(rst),
    .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .d_in_a(d_in_a), .d_out_a(qa[0]), .valid_a(va[0]),
    .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .d_in_b(d_in_b), .d_out_b(qb[0]), .valid_b(vb[0]),
    .collision(co[0]));
  bram_tdp_be_pipe #(.DEPTH(2000), .RD_MODE(1), .OUT_REG(0)) d1 (
    .clk(clk), .rst(rst),
    .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .d_in_a(d_in_a), .d_out_a(qa[1]), .valid_a(va[1]),
    .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .d_in_b(d_in_b), .d_out_b(qb[1]), .valid_b(vb[1]),
    .collision(co[1]));
  bram_tdp_be_pipe #(.DEPTH(2048), .RD_MODE(2), .OUT_REG(0)) d2 (
    .clk(clk), .rst(rst),
    .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .d_in_a(d_in_a), .d_out_a(qa[2]), .valid_a(va[2]),
    .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .d_in_b(d_in_b), .d_out_b(qb[2]), .valid_b(vb[2]),
    .collision(co[2]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] we);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (we[i]) r[8*i+:8] = d[8*i+:8];
    return r;
  endfunction

  task automatic clear_model();
    for (int k = 0; k < 3; k++) begin
      ce[k] = 1'b0;
      for (int p = 0; p < 2; p++) begin
        s1[k][p] = '0; s2[k][p] = '0; v1[k][p] = 1'b0; v2[k][p] = 1'b0;
      end
    end
  endtask

  task automatic model_edge();
    logic        en [2];
    logic [3:0]  we [2];
    logic [10:0] ad [2];
    logic [31:0] dd [2];
    logic [31:0] rn [2];
    logic        inr [2];
    en[0] = en_a; we[0] = we_a; ad[0] = addr_a; dd[0] = d_in_a;
    en[1] = en_b; we[1] = we_b; ad[1] = addr_b; dd[1] = d_in_b;
    for (int k = 0; k < 3; k++) begin
      for (int p = 0; p < 2; p++) begin
        inr[p] = int'(ad[p]) < dep[k];
        if (!en[p]) rn[p] = s1[k][p];
        else if (!inr[p]) rn[p] = '0;
        else if (we[p] == 0 || mode[k] == 0) rn[p] = mm[k][ad[p]];
        else if (mode[k] == 1) rn[p] = merge(mm[k][ad[p]], dd[p], we[p]);
        else rn[p] = s1[k][p];
      end
      ce[k] = en[0] && en[1] && inr[0] && inr[1] && ad[0] == ad[1] && (we[0] != 0 || we[1] != 0);
      if (en[1] && inr[1]) mm[k][ad[1]] = merge(mm[k][ad[1]], dd[1], we[1]);
      if (en[0] && inr[0]) mm[k][ad[0]] = merge(mm[k][ad[0]], dd[0], we[0]);
      for (int p = 0; p < 2; p++) begin
        s2[k][p] = s1[k][p]; v2[k][p] = v1[k][p];
        s1[k][p] = rn[p];    v1[k][p] = en[p];
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("d%0d_qa", k), qa[k], lat[k] == 2 ? s2[k][0] : s1[k][0]);
      chk($sformatf("d%0d_qb", k), qb[k], lat[k] == 2 ? s2[k][1] : s1[k][1]);
      chk($sformatf("d%0d_va", k), 32'(va[k]), 32'(lat[k] == 2 ? v2[k][0] : v1[k][0]));
      chk($sformatf("d%0d_vb", k), 32'(vb[k]), 32'(lat[k] == 2 ? v2[k][1] : v1[k][1]));
      chk($sformatf("d%0d_col", k), 32'(co[k]), 32'(ce[k]));
    end
  endtask

  task automatic check_zero(input string tag);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s_d%0d_qa", tag, k), qa[k], 32'h0);
      chk($sformatf("%s_d%0d_qb", tag, k), qb[k], 32'h0);
      chk($sformatf("%s_d%0d_v", tag, k), {30'h0, va[k], vb[k]}, 32'h0);
      chk($sformatf("%s_d%0d_col", tag, k), 32'(co[k]), 32'h0);
    end
  endtask

  task automatic cyc(input logic ea, input logic [3:0] wa, input logic [10:0] aa, input logic [31:0] da,
                     input logic eb, input logic [3:0] wb, input logic [10:0] ab, input logic [31:0] db);
    en_a = ea; we_a = wa; addr_a = aa; d_in_a = da;
    en_b = eb; we_b = wb; addr_b = ab; d_in_b = db;
    @(posedge clk);
    model_edge();
    #1 check_all();
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  function automatic logic [10:0] raddr();
    int r;
    r = $urandom_range(0, 19);
    return r < 16 ? 11'(r) : r == 16 ? 11'd1999 : r == 17 ? 11'd2000 : 11'd2047;
  endfunction

  task automatic rand_cyc();
    logic [3:0] wa, wb;
    wa = $urandom_range(0, 1) ? 4'(($urandom)) : 4'h0;
    wb = $urandom_range(0, 1) ? 4'(($urandom)) : 4'h0;
    cyc($urandom_range(0, 3) != 0, wa, raddr(), $urandom, $urandom_range(0, 3) != 0, wb, raddr(), $urandom);
  endtask

  initial begin
    logic [10:0] ia;
    rst = 1'b1;
    en_a = 0; we_a = 0; addr_a = 0; d_in_a = 0;
    en_b = 0; we_b = 0; addr_b = 0; d_in_b = 0;
    clear_model();
    repeat (2) @(posedge clk);
    #1 check_zero("reset");
    rst = 1'b0;
    for (int i = 0; i < 19; i++) begin
      ia = i < 16 ? 11'(i) : i == 16 ? 11'd1999 : i == 17 ? 11'd2000 : 11'd2047;
      cyc(1, 4'hF, ia, $urandom, 0, 0, 0, 0);
    end
    cyc(1, 4'hF, 5, 32'hDEADBEEF, 0, 0, 0, 0);
    cyc(1, 4'b0101, 5, 32'h11223344, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 5, 0);
    chk("t2_lat1_qb", qb[1], 32'hDE22BE44);
    chk("t2_lat1_vb", 32'(vb[1]), 32'h1);
    idle();
    chk("t2_lat2_qb", qb[0], 32'hDE22BE44);
    chk("t2_lat2_vb", 32'(vb[0]), 32'h1);
    chk("t2_lat1_bubble", 32'(vb[1]), 32'h0);
    cyc(1, 4'hF, 7, 32'hAAAA0000, 0, 0, 0, 0);
    cyc(1, 4'h0, 7, 0, 0, 0, 0, 0);
    cyc(1, 4'hF, 7, 32'h5555FFFF, 0, 0, 0, 0);
    chk("t3_wfirst", qa[1], 32'h5555FFFF);
    chk("t3_nochg", qa[2], 32'hAAAA0000);
    chk("t3_nochg_v", 32'(va[2]), 32'h1);
    idle();
    chk("t3_rfirst", qa[0], 32'hAAAA0000);
    cyc(1, 4'hF, 9, 32'hFFFFFFFF, 0, 0, 0, 0);
    cyc(1, 4'b0011, 9, 32'h01010101, 1, 4'b0110, 9, 32'h02020202);
    chk("t4_col", 32'(co[0]), 32'h1);
    idle();
    chk("t4_col_one", 32'(co[0]), 32'h0);
    cyc(0, 0, 0, 0, 1, 0, 9, 0);
    idle();
    chk("t4_mem9", qb[0], 32'hFF020101);
    cyc(1, 4'hF, 3, 32'h0, 0, 0, 0, 0);
    cyc(1, 4'h0, 3, 0, 1, 4'hF, 3, 32'h12345678);
    chk("t5_old", qa[1], 32'h0);
    chk("t5_col", 32'(co[1]), 32'h1);
    cyc(1, 4'h0, 3, 0, 0, 0, 0, 0);
    chk("t5_new", qa[1], 32'h12345678);
    cyc(1, 4'hF, 2047, 32'hCAFEF00D, 0, 0, 0, 0);
    cyc(1, 4'h0, 2047, 0, 1, 0, 1999, 0);
    chk("t6_oor_q", qa[1], 32'h0);
    chk("t6_oor_v", 32'(va[1]), 32'h1);
    cyc(1, 4'h0, 0, 0, 1, 0, 1999, 0);
    idle();
    for (int i = 0; i < 6; i++) rand_cyc();
    en_a = 0; we_a = 0; en_b = 0; we_b = 0;
    rst = 1'b1;
    #1 check_zero("t1_async");
    clear_model();
    @(posedge clk);
    #1 rst = 1'b0;
    cyc(1, 0, 5, 0, 1, 0, 9, 0);
    cyc(1, 0, 7, 0, 1, 0, 3, 0);
    idle();
    for (int i = 0; i < 400; i++) rand_cyc();
    for (int i = 0; i < 19; i++) begin
      ia = i < 16 ? 11'(i) : i == 16 ? 11'd1999 : i == 17 ? 11'd2000 : 11'd2047;
      cyc(1, 0, ia, 0, 1, 0, ia, 0);
    end
    idle();
    idle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
